// File: rtl/matrix_store_writer_if.sv
// Handshake, memory-write and metadata signals of the matrix store writer.
// master drives headers, elements, aborts and clears; slave is the writer itself.
interface matrix_store_writer_if #(
    parameter int unsigned SLOTS  = 10,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_m;
    logic [2:0]            cmd_n;
    logic                  elem_valid;
    logic                  elem_ready;
    logic [DATA_W-1:0]     elem_data;
    logic                  wr_abort;
    logic                  clr_valid;
    logic [3:0]            clr_id;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [3*SLOTS-1:0]    meta_m_flat;
    logic [3*SLOTS-1:0]    meta_n_flat;
    logic [SLOTS-1:0]      meta_valid;
    logic                  wr_done;
    logic [3:0]            wr_slot;
    logic                  wr_error;
    logic                  busy;
    logic [3:0]            valid_count;

    modport master (
        output cmd_valid, cmd_m, cmd_n, elem_valid, elem_data, wr_abort, clr_valid, clr_id,
        input  cmd_ready, elem_ready, mem_we, mem_addr, mem_wdata, meta_m_flat, meta_n_flat,
               meta_valid, wr_done, wr_slot, wr_error, busy, valid_count
    );

    modport slave (
        input  cmd_valid, cmd_m, cmd_n, elem_valid, elem_data, wr_abort, clr_valid, clr_id,
        output cmd_ready, elem_ready, mem_we, mem_addr, mem_wdata, meta_m_flat, meta_n_flat,
               meta_valid, wr_done, wr_slot, wr_error, busy, valid_count
    );
endinterface

// File: rtl/matrix_store_writer.sv
// Write side of the matrix metadata table: allocates a slot, streams elements
// into the shared matrix memory and publishes per-slot m/n/valid metadata.
module matrix_store_writer #(
    parameter int unsigned SLOTS   = 10,
    parameter int unsigned MAX_DIM = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    matrix_store_writer_if.slave     bus
);
    localparam int unsigned DIM_W = 3;
    localparam int unsigned ID_W  = 4;
    localparam int unsigned CELLS = MAX_DIM * MAX_DIM;
    localparam int unsigned CNT_W = $clog2(CELLS + 1);

    typedef enum logic [2:0] {IDLE, CHECK, ALLOC, WRITE, COMMIT} state_t;

    state_t            state;
    logic [DIM_W-1:0]  m_q, n_q;
    logic [ID_W-1:0]   target, rr_ptr, free_idx, alloc_idx;
    logic              all_valid;
    logic [CNT_W-1:0]  cnt, last_idx;
    logic [ADDR_W-1:0] wr_addr;
    logic              dims_bad;

    assign bus.cmd_ready   = (state == IDLE) && !bus.clr_valid;
    assign bus.elem_ready  = (state == WRITE);
    assign bus.valid_count = ID_W'($countones(bus.meta_valid));

    assign last_idx = CNT_W'(m_q) * CNT_W'(n_q) - CNT_W'(1);
    assign wr_addr  = ADDR_W'(target) * ADDR_W'(CELLS) + ADDR_W'(cnt);
    assign dims_bad = (m_q == '0) || (n_q == '0) ||
                      (m_q > DIM_W'(MAX_DIM)) || (n_q > DIM_W'(MAX_DIM));

    // Lowest free slot; falls back to the round-robin victim when the table is full.
    always_comb begin
        free_idx  = '0;
        all_valid = 1'b1;
        for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
            if (!bus.meta_valid[i]) begin
                free_idx  = ID_W'(i);
                all_valid = 1'b0;
            end
        end
        alloc_idx = all_valid ? rr_ptr : free_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            m_q             <= '0;
            n_q             <= '0;
            target          <= '0;
            rr_ptr          <= '0;
            cnt             <= '0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.meta_m_flat <= '0;
            bus.meta_n_flat <= '0;
            bus.meta_valid  <= '0;
            bus.wr_done     <= 1'b0;
            bus.wr_slot     <= '0;
            bus.wr_error    <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.mem_we   <= 1'b0;
            bus.wr_done  <= 1'b0;
            bus.wr_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clr_valid) begin
                        if (bus.clr_id < ID_W'(SLOTS)) bus.meta_valid[bus.clr_id] <= 1'b0;
                        else                           bus.wr_error <= 1'b1;
                    end else if (bus.cmd_valid) begin
                        m_q      <= bus.cmd_m;
                        n_q      <= bus.cmd_n;
                        state    <= CHECK;
                        bus.busy <= 1'b1;
                    end
                end
                CHECK: begin
                    if (bus.wr_abort || dims_bad) begin
                        bus.wr_error <= 1'b1;
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                    end else begin
                        state <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (bus.wr_abort) begin
                        bus.wr_error <= 1'b1;
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                    end else begin
                        // Hide the target before any element lands in it.
                        target                    <= alloc_idx;
                        bus.meta_valid[alloc_idx] <= 1'b0;
                        if (all_valid)
                            rr_ptr <= (rr_ptr == ID_W'(SLOTS - 1)) ? '0 : rr_ptr + ID_W'(1);
                        cnt   <= '0;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus.wr_abort) begin
                        bus.wr_error <= 1'b1;
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                    end else if (bus.elem_valid) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= wr_addr;
                        bus.mem_wdata <= bus.elem_data;
                        cnt           <= cnt + CNT_W'(1);
                        if (cnt == last_idx) state <= COMMIT;
                    end
                end
                COMMIT: begin
                    bus.meta_m_flat[DIM_W*target +: DIM_W] <= m_q;
                    bus.meta_n_flat[DIM_W*target +: DIM_W] <= n_q;
                    bus.meta_valid[target]                 <= 1'b1;
                    bus.wr_slot                            <= target;
                    bus.wr_done                            <= 1'b1;
                    state                                  <= IDLE;
                    bus.busy                               <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_store_writer.sv
// Randomised scoreboard bench for matrix_store_writer against a slot-table model.
module tb_matrix_store_writer;
    localparam int unsigned SLOTS   = 10;
    localparam int unsigned MAX_DIM = 5;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned CELLS   = MAX_DIM * MAX_DIM;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_store_writer_if #(.SLOTS(SLOTS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    matrix_store_writer #(.SLOTS(SLOTS), .MAX_DIM(MAX_DIM), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
    typedef struct packed { logic is_err; logic [3:0] slot; } ev_t;

    wr_t exp_wr[$];
    ev_t exp_ev[$];
    int  errors = 0;
    int  checks = 0;

    bit  mdl_valid[SLOTS];
    int  mdl_m[SLOTS];
    int  mdl_n[SLOTS];
    int  mdl_rr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mdl_reset();
        for (int i = 0; i < int'(SLOTS); i++) begin
            mdl_valid[i] = 1'b0; mdl_m[i] = 0; mdl_n[i] = 0;
        end
        mdl_rr = 0;
    endfunction

    function automatic int mdl_alloc();
        int t;
        for (int i = 0; i < int'(SLOTS); i++) if (!mdl_valid[i]) return i;
        t      = mdl_rr;
        mdl_rr = (mdl_rr + 1) % int'(SLOTS);
        return t;
    endfunction

    // Monitor: every write strobe and every done/error pulse must match the scoreboard head.
    wr_t mon_w;
    ev_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_we) begin
                if (exp_wr.size() == 0) check("unexpected_mem_we", 64'(bus.mem_addr), 64'hFFFF);
                else begin
                    mon_w = exp_wr.pop_front();
                    check("mem_addr", 64'(bus.mem_addr), 64'(mon_w.addr));
                    check("mem_wdata", 64'(bus.mem_wdata), 64'(mon_w.data));
                end
            end
            if (bus.wr_done || bus.wr_error) begin
                check("done_error_exclusive", 64'(bus.wr_done & bus.wr_error), 64'(0));
                if (exp_ev.size() == 0) check("unexpected_pulse", 64'({bus.wr_error, bus.wr_done}), 64'(0));
                else begin
                    mon_e = exp_ev.pop_front();
                    check("pulse_kind_is_err", 64'(bus.wr_error), 64'(mon_e.is_err));
                    if (!mon_e.is_err) check("wr_slot", 64'(bus.wr_slot), 64'(mon_e.slot));
                end
            end
        end
    end

    task automatic check_meta(input string tag);
        logic [SLOTS-1:0]   v;
        logic [3*SLOTS-1:0] fm, fn;
        int                 c;
        c = 0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            v[i]        = mdl_valid[i];
            fm[3*i +: 3] = 3'(mdl_m[i]);
            fn[3*i +: 3] = 3'(mdl_n[i]);
            c += int'(mdl_valid[i]);
        end
        check({tag, "_meta_valid"}, 64'(bus.meta_valid), 64'(v));
        check({tag, "_meta_m"}, 64'(bus.meta_m_flat), 64'(fm));
        check({tag, "_meta_n"}, 64'(bus.meta_n_flat), 64'(fn));
        check({tag, "_valid_count"}, 64'(bus.valid_count), 64'(c));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_we"}, 64'(bus.mem_we), 64'(0));
        check({tag, "_wr_done"}, 64'(bus.wr_done), 64'(0));
        check({tag, "_wr_error"}, 64'(bus.wr_error), 64'(0));
        check({tag, "_wr_slot"}, 64'(bus.wr_slot), 64'(0));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_elem_ready"}, 64'(bus.elem_ready), 64'(0));
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        check_meta(tag);
    endtask

    // Ends at a negedge with the DUT idle; cyc counts extra cycles busy stayed high.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (bus.busy && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_timeout", 64'(bus.busy), 64'(0));
    endtask

    task automatic send_cmd(input int m, input int n);
        bit rdy;
        int cyc;
        cyc = 0;
        bus.cmd_valid = 1'b1; bus.cmd_m = 3'(m); bus.cmd_n = 3'(n);
        forever begin
            @(negedge clk); rdy = bus.cmd_ready;
            @(posedge clk); #1;
            if (rdy) break;
            cyc++;
            if (cyc > 50) begin check("cmd_accept_timeout", 64'(rdy), 64'(1)); break; end
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic reset_dut();
        bus.elem_valid = 1'b0; bus.wr_abort = 1'b0; bus.cmd_valid = 1'b0; bus.clr_valid = 1'b0;
        rst = 1'b1;
        #1;
        mdl_reset();
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Header plus element stream; abort_at/rst_at >= 1 interrupts after that many elements.
    task automatic do_write(input int m, input int n, input int abort_at, input int rst_at, input bit seq_data);
        bit                legal;
        int                k, t, hs, cyc;
        logic [DATA_W-1:0] d;
        legal = m >= 1 && n >= 1 && m <= int'(MAX_DIM) && n <= int'(MAX_DIM);
        k = m * n; t = 0; hs = 0; cyc = 0;
        if (!legal) exp_ev.push_back('{is_err: 1'b1, slot: 4'd0});
        else begin
            t = mdl_alloc();
            mdl_valid[t] = 1'b0;
        end
        send_cmd(m, n);
        if (!legal) begin
            wait_idle(cyc);
            check("bad_header_idle_cycles", 64'(cyc), 64'(1));
            check_meta("bad_header");
            @(posedge clk); #1;
            return;
        end
        while (hs < k && cyc < 500) begin
            if (abort_at >= 1 && hs == abort_at) begin
                exp_ev.push_back('{is_err: 1'b1, slot: 4'd0});
                bus.elem_valid = 1'b1; bus.elem_data = DATA_W'($urandom); bus.wr_abort = 1'b1;
                @(posedge clk); #1;
                bus.wr_abort = 1'b0;
                break;
            end
            if (rst_at >= 1 && hs == rst_at) break;
            d = seq_data ? DATA_W'(hs + 1) : DATA_W'($urandom);
            bus.elem_valid = ($urandom_range(3) != 0);
            bus.elem_data  = d;
            @(negedge clk);
            if (bus.elem_valid && bus.elem_ready) begin
                exp_wr.push_back('{addr: ADDR_W'(t * int'(CELLS) + hs), data: d});
                if (hs == 0) check("target_hidden_during_write", 64'(bus.meta_valid[t]), 64'(0));
                hs++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.elem_valid = 1'b0;
        if (cyc >= 500) check("element_stream_timeout", 64'(hs), 64'(k));
        if (rst_at >= 1) begin
            @(negedge clk);
            @(posedge clk); #1;
            reset_dut();
            return;
        end
        if (abort_at < 1) exp_ev.push_back('{is_err: 1'b0, slot: 4'(t)});
        wait_idle(cyc);
        if (abort_at < 1) begin
            mdl_valid[t] = 1'b1; mdl_m[t] = m; mdl_n[t] = n;
        end
        check_meta(abort_at >= 1 ? "abort" : "commit");
        @(posedge clk); #1;
    endtask

    task automatic do_clear(input int id, input bit with_cmd);
        bus.clr_valid = 1'b1; bus.clr_id = 4'(id);
        bus.cmd_valid = with_cmd; bus.cmd_m = 3'd1; bus.cmd_n = 3'd1;
        @(negedge clk);
        check("clear_blocks_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        if (id < int'(SLOTS)) mdl_valid[id] = 1'b0;
        else exp_ev.push_back('{is_err: 1'b1, slot: 4'd0});
        @(posedge clk); #1;
        bus.clr_valid = 1'b0; bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("clear_busy", 64'(bus.busy), 64'(0));
        check_meta("clear");
        @(posedge clk); #1;
    endtask

    initial begin
        int m, n, r, k;
        bus.cmd_valid = 1'b0; bus.cmd_m = '0; bus.cmd_n = '0;
        bus.elem_valid = 1'b0; bus.elem_data = '0; bus.wr_abort = 1'b0;
        bus.clr_valid = 1'b0; bus.clr_id = '0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("initial");
        rst = 1'b0;

        do_write(2, 3, 0, 0, 1'b1);
        for (int i = 1; i < int'(SLOTS); i++) do_write(1, 1, 0, 0, 1'b0);
        do_write(2, 2, 0, 0, 1'b0);
        check("eleventh_write_slot", 64'(bus.wr_slot), 64'(0));
        do_write(1, 3, 0, 0, 1'b0);
        check("twelfth_write_slot", 64'(bus.wr_slot), 64'(1));

        do_write(0, 3, 0, 0, 1'b0);
        do_write(6, 2, 0, 0, 1'b0);
        do_write(3, 0, 0, 0, 1'b0);
        do_write(2, 7, 0, 0, 1'b0);
        do_write(3, 3, 4, 0, 1'b0);

        @(posedge clk); #1;
        reset_dut();
        for (int i = 0; i < 3; i++) do_write(1, 1, 0, 0, 1'b0);
        do_clear(1, 1'b1);
        check("cleared_pattern", 64'(bus.meta_valid), 64'(10'b0000000101));
        do_write(2, 2, 0, 0, 1'b0);
        check("refill_after_clear_slot", 64'(bus.wr_slot), 64'(1));
        do_clear(12, 1'b0);

        do_write(2, 2, 0, 2, 1'b0);
        do_write(1, 2, 0, 0, 1'b0);
        check("write_after_reset_slot", 64'(bus.wr_slot), 64'(0));

        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(9));
            m = int'($urandom_range(1, MAX_DIM));
            n = int'($urandom_range(1, MAX_DIM));
            if (r == 0) do_clear(int'($urandom_range(15)), 1'($urandom_range(1)));
            else if (r == 1) do_write(($urandom_range(1) != 0) ? 0 : 6 + int'($urandom_range(1)), n, 0, 0, 1'b0);
            else if (r == 2) begin
                if (m * n < 2) n = 2;
                k = m * n;
                do_write(m, n, int'($urandom_range(1, k - 1)), 0, 1'b0);
            end
            else do_write(m, n, 0, 0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("pending_writes", 64'(exp_wr.size()), 64'(0));
        check("pending_pulses", 64'(exp_ev.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
